// File: rtl/fetch_pkg.sv
// Shared constants and the fetch-queue entry layout used by the IF stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] instr;
    logic        filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fq_mem.sv
// Fetch-queue storage: entries allocated at tail, filled in order, popped at head; 1-cycle write latency.
// No internal flow control; the caller guarantees alloc only when not full and fill only to allocated entries.
module fetch_fq_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        alloc_i,
  input  logic [31:0] alloc_pc_i,
  input  logic        alloc_taken_i,
  input  logic        fill_i,
  input  logic [31:0] fill_instr_i,
  input  logic        pop_i,
  output fq_entry_t   head_o
);

  fq_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     head_q;
  logic [AW-1:0]     tail_q;
  logic [AW-1:0]     fill_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i].filled <= 1'b0;
      end
    end else begin
      if (alloc_i) begin
        mem_q[tail_q] <= '{pc: alloc_pc_i, taken: alloc_taken_i, instr: NOP_INSTR, filled: 1'b0};
        tail_q        <= tail_q + 1'b1;
      end
      // Fill and pop never address the same entry: pop needs a filled head, fill an unfilled one.
      if (fill_i) begin
        mem_q[fill_q].instr  <= fill_instr_i;
        mem_q[fill_q].filled <= 1'b1;
        fill_q               <= fill_q + 1'b1;
      end
      if (pop_i) begin
        mem_q[head_q].filled <= 1'b0;
        head_q               <= head_q + 1'b1;
      end
    end
  end

  assign head_o = mem_q[head_q];

endmodule

// File: rtl/fetch_queue_stage.sv
// IF stage: fetch PC, in-order imem requests, queue to decode; decode sees a response one cycle after it returns.
// Issue stops when the queue is full; flush redirects and drops in-flight responses. FETCH_PERF_EN adds perf counters.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          FQ_DEPTH = 4,
  parameter int          FQ_AW    = $clog2(FQ_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        taken_F,
  input  logic        flush,
  input  logic [31:0] pc_restore,
  output logic [31:0] pc_F,
  output logic [31:0] pc4,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_D,
  output logic        valid_D,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic        taken_D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam logic [FQ_AW:0] FULL = (FQ_AW + 1)'(FQ_DEPTH);

  logic [31:0]    pc_q, pc_d;
  logic [FQ_AW:0] occ_q, occ_d;
  logic [FQ_AW:0] infl_q, infl_d;
  logic [FQ_AW:0] drop_q, drop_d;
  logic           hs, pop, rsp_fill, rsp_drop;
  fq_entry_t      head;

  assign imem_req_valid = !rst && !flush && (occ_q != FULL);
  assign hs             = imem_req_valid && imem_req_ready;
  assign valid_D        = (occ_q != '0) && head.filled;
  assign pop            = valid_D && !stall_D && !flush;
  assign rsp_drop       = imem_rsp_valid && (flush || (drop_q != '0));
  assign rsp_fill       = imem_rsp_valid && !flush && (drop_q == '0);

  // infl_q counts allocated-but-unfilled entries; on flush they become stale responses to drop.
  always_comb begin
    pc_d   = pc_q;
    occ_d  = occ_q;
    infl_d = infl_q;
    drop_d = drop_q;
    if (flush) begin
      pc_d   = pc_restore;
      occ_d  = '0;
      infl_d = '0;
      drop_d = drop_q + infl_q - (FQ_AW + 1)'(imem_rsp_valid);
    end else begin
      if (hs) pc_d = pc_next;
      occ_d  = occ_q + (FQ_AW + 1)'(hs) - (FQ_AW + 1)'(pop);
      infl_d = infl_q + (FQ_AW + 1)'(hs) - (FQ_AW + 1)'(rsp_fill);
      drop_d = drop_q - (FQ_AW + 1)'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      occ_q  <= '0;
      infl_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      occ_q  <= occ_d;
      infl_q <= infl_d;
      drop_q <= drop_d;
    end
  end

  fetch_fq_mem #(.DEPTH(FQ_DEPTH), .AW(FQ_AW)) u_fq_mem (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (flush),
    .alloc_i       (hs),
    .alloc_pc_i    (pc_q),
    .alloc_taken_i (taken_F),
    .fill_i        (rsp_fill),
    .fill_instr_i  (imem_rsp_data),
    .pop_i         (pop),
    .head_o        (head)
  );

  assign pc_F          = pc_q;
  assign pc4           = pc_q + 32'd4;
  assign imem_req_addr = pc_q;
  assign instr_D       = valid_D ? head.instr : NOP_INSTR;
  assign pc_D          = valid_D ? head.pc    : 32'h0;
  assign taken_D       = valid_D ? head.taken : 1'b0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_flush_q, perf_drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_flush_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (flush)    perf_flush_q <= perf_flush_q + 32'd1;
      if (rsp_drop) perf_drop_q  <= perf_drop_q + 32'd1;
    end
  end

  assign perf_flush_cnt = perf_flush_q;
  assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule
